// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and constants for the FIFO write-side arbiter.
//   arb_state_t  : arbiter FSM state (IDLE / BURST)
//   DEF_NREQ     : default number of requesters
//   DEF_MAXBURST : default beat limit per grant
//   gnt_width()  : width of a requester index (at least 1 bit)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAXBURST = 16;

  function automatic int gnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. The search starts one past the previous
// grantee and wraps, so the most recently served requester has lowest priority.
// Ports:
//   valid    in  NREQ  requesters currently asking
//   last_gnt in  GW    index of the previous grantee
//   winner   out GW    selected requester (0 when none)
//   any      out 1     at least one requester is valid
module rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GW-1:0]   last_gnt,
  output logic [GW-1:0]   winner,
  output logic            any
);

  int idx;

  // Walk offsets 1..NREQ from last_gnt; the first valid hit wins. Offset NREQ
  // lands back on last_gnt itself, so a lone requester can be re-granted.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_gnt) + k) % NREQ;
      if (!any && |(valid & (NREQ'(1) << idx))) begin
        winner = GW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// Packet-locked round-robin arbiter feeding the write port of a FIFO.
// A requester is chosen in IDLE (one cycle of arbitration latency) and then
// owns the FIFO until its packet ends or MAXBURST beats have been written.
// Ports:
//   wclk, wrst_n  clock and asynchronous active-low reset
//   arb_en        allows new grants (an active burst always completes)
//   req_valid     per-requester beat valid
//   req_last      per-requester last beat of packet
//   req_data      per-requester data, requester i at [i*DSIZE +: DSIZE]
//   req_ready     per-requester beat accept
//   wfull         FIFO full flag
//   winc, wdata   FIFO write strobe and data
//   gnt_id        current / most recent grantee
//   busy          high while a burst owns the FIFO
//   trunc         one-cycle pulse after a burst is cut at MAXBURST
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int NREQ     = DEF_NREQ,
  parameter int MAXBURST = DEF_MAXBURST,
  localparam int GW      = gnt_width(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  arb_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [GW-1:0]         gnt_id,
  output logic                  busy,
  output logic                  trunc
);

  localparam int             CW      = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAXBURST);

  arb_state_t    state, state_nxt;
  logic [GW-1:0] gnt_nxt, last_gnt, last_gnt_nxt, winner;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          trunc_nxt, any_valid, beat, is_last;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .valid    (req_valid),
    .last_gnt (last_gnt),
    .winner   (winner),
    .any      (any_valid)
  );

  assign busy    = (state == BURST);
  // Accept only when the FIFO has room, so winc can never coincide with wfull.
  assign beat    = busy & req_valid[gnt_id] & ~wfull;
  assign winc    = beat;
  assign wdata   = req_data[int'(gnt_id)*DSIZE +: DSIZE];
  assign is_last = req_last[gnt_id];
  assign cnt_inc = cnt + CW'(1);

  // Only the grantee sees ready, and only while the FIFO can take a beat.
  always_comb begin
    req_ready = '0;
    if (busy) req_ready[gnt_id] = ~wfull;
  end

  // Next-state logic. A dropped req_valid simply stalls the burst: the grant
  // is released only by a last beat or by reaching MAXBURST.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_id;
    last_gnt_nxt = last_gnt;
    cnt_nxt      = cnt;
    trunc_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_en && any_valid) begin
          state_nxt = BURST;
          gnt_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_nxt = cnt_inc;
          if (is_last) begin
            state_nxt    = IDLE;
            last_gnt_nxt = gnt_id;
            cnt_nxt      = '0;
          end else if (cnt_inc == MAX_CNT) begin
            state_nxt    = IDLE;
            last_gnt_nxt = gnt_id;
            cnt_nxt      = '0;
            trunc_nxt    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_gnt resets to NREQ-1 so requester 0 is first in line after reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt_id   <= '0;
      last_gnt <= GW'(NREQ - 1);
      cnt      <= '0;
      trunc    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_id   <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      cnt      <= cnt_nxt;
      trunc    <= trunc_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
// Self-checking bench for fifo_wr_arb. A default instance (MAXBURST=16) and
// a MAXBURST=4 instance share all inputs; each check targets one of them.
module tb_fifo_wr_arb;

  logic        wclk = 1'b0;
  logic        wrst_n, arb_en, wfull;
  logic [3:0]  req_valid, req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready, req_ready4;
  logic        winc, winc4, busy, busy4, trunc, trunc4;
  logic [7:0]  wdata, wdata4;
  logic [1:0]  gnt_id, gnt_id4;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.DSIZE(8), .NREQ(4), .MAXBURST(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .arb_en(arb_en), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .wfull(wfull), .winc(winc), .wdata(wdata), .gnt_id(gnt_id),
    .busy(busy), .trunc(trunc)
  );

  fifo_wr_arb #(.DSIZE(8), .NREQ(4), .MAXBURST(4)) dut4 (
    .wclk(wclk), .wrst_n(wrst_n), .arb_en(arb_en), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data), .req_ready(req_ready4),
    .wfull(wfull), .winc(winc4), .wdata(wdata4), .gnt_id(gnt_id4),
    .busy(busy4), .trunc(trunc4)
  );

  typedef struct packed {
    logic       sel4;
    logic       arb_en;
    logic [3:0] valid;
    logic [3:0] last;
    logic       wfull;
    logic [3:0] e_ready;
    logic       e_winc;
    logic       e_busy;
    logic       e_trunc;
    logic [1:0] e_gnt;
    logic [7:0] e_data;
  } vec_t;

  vec_t        vecs [$];
  logic [8:0]  src_q [4][$];
  logic [9:0]  exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          acc_cnt, stall_after, stall_left;
  logic [1:0]  stall_gnt;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dv(input int r, input int k);
    return {r[3:0], k[3:0]};
  endfunction

  task automatic loadBeat(input int r, input int k, input logic last);
    src_q[r].push_back({last, dv(r, k)});
  endtask

  task automatic loadPacket(input int r, input int first, input int n);
    for (int k = first; k < first + n; k++) loadBeat(r, k, (k == first + n - 1));
  endtask

  task automatic expectBeat(input int r, input int k);
    logic [1:0] g;
    g = r[1:0];
    exp_q.push_back({g, dv(r, k)});
  endtask

  task automatic driveSources();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_last[i]        = h[8];
        req_data[i*8 +: 8] = h[7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // One clock of the source model on the default instance; entered and left
  // on a falling edge. Writes are scored against exp_q, accepted beats popped.
  task automatic applyStimulus();
    logic       acc;
    logic [1:0] acc_g;
    logic [9:0] e;
    acc   = 1'b0;
    acc_g = 2'd0;
    driveSources();
    wfull = 1'b0;
    if (stall_left > 0 && acc_cnt >= stall_after) begin
      wfull = 1'b1;
      stall_left--;
    end
    #1;
    if (wfull) begin
      checkOutput("stall_winc", winc, 0);
      checkOutput("stall_busy", busy, 1);
      checkOutput("stall_gnt", gnt_id, stall_gnt);
    end
    if (winc) begin
      acc   = 1'b1;
      acc_g = gnt_id;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got gnt=%0d data=%h expected no write",
                 gnt_id, wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write", {gnt_id, wdata}, e);
      end
    end
    @(posedge wclk);
    if (acc) begin
      void'(src_q[acc_g].pop_front());
      acc_cnt++;
    end
    @(negedge wclk);
  endtask

  task automatic runUntilEmpty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  task automatic applyReset();
    wrst_n    = 1'b0;
    arb_en    = 1'b1;
    wfull     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    acc_cnt     = 0;
    stall_after = 0;
    stall_left  = 0;
    stall_gnt   = 2'd0;
    @(negedge wclk);
    checkOutput("reset_main", {req_ready, winc, busy, trunc, gnt_id}, 0);
    checkOutput("reset_dut4", {req_ready4, winc4, busy4, trunc4, gnt_id4}, 0);
    wrst_n = 1'b1;
  endtask

  task automatic addVec(input logic sel4, input logic arb, input logic [3:0] valid,
                        input logic [3:0] last, input logic full,
                        input logic [3:0] e_ready, input logic e_winc,
                        input logic e_busy, input logic e_trunc,
                        input logic [1:0] e_gnt, input logic [7:0] e_data);
    vec_t v;
    v.sel4 = sel4; v.arb_en = arb; v.valid = valid; v.last = last; v.wfull = full;
    v.e_ready = e_ready; v.e_winc = e_winc; v.e_busy = e_busy;
    v.e_trunc = e_trunc; v.e_gnt = e_gnt; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  // Table rows hold inputs fixed for one cycle; requester i drives 8'hA0+i.
  task automatic runTable(input string name);
    vec_t        v;
    logic [18:0] act, exp;
    for (int i = 0; i < vecs.size(); i++) begin
      v         = vecs[i];
      arb_en    = v.arb_en;
      req_valid = v.valid;
      req_last  = v.last;
      wfull     = v.wfull;
      req_data  = 32'hA3A2A1A0;
      #1;
      if (v.sel4)
        act = {req_ready4, winc4, busy4, trunc4, gnt_id4, (winc4 ? wdata4 : 8'h00)};
      else
        act = {req_ready, winc, busy, trunc, gnt_id, (winc ? wdata : 8'h00)};
      exp = {v.e_ready, v.e_winc, v.e_busy, v.e_trunc, v.e_gnt,
             (v.e_winc ? v.e_data : 8'h00)};
      checkOutput($sformatf("%s[%0d]", name, i), act, exp);
      @(negedge wclk);
    end
    vecs.delete();
  endtask

  initial begin
    // Two single-beat requesters: grants 1 then 2.
    applyReset();
    addVec(0, 1, 4'b0110, 4'b0110, 0, 4'b0000, 0, 0, 0, 2'd0, 8'h00);
    addVec(0, 1, 4'b0110, 4'b0110, 0, 4'b0010, 1, 1, 0, 2'd1, 8'hA1);
    addVec(0, 1, 4'b0100, 4'b0100, 0, 4'b0000, 0, 0, 0, 2'd1, 8'h00);
    addVec(0, 1, 4'b0100, 4'b0100, 0, 4'b0100, 1, 1, 0, 2'd2, 8'hA2);
    addVec(0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd2, 8'h00);
    runTable("two_req");

    // MAXBURST=4: requester 0 streams with one stall, is cut after 4 beats,
    // then pending requester 1 is served before 0 returns.
    applyReset();
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0000, 0, 0, 0, 2'd0, 8'h00);
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0001, 1, 1, 0, 2'd0, 8'hA0);
    addVec(1, 1, 4'b0011, 4'b0010, 1, 4'b0000, 0, 1, 0, 2'd0, 8'h00);
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0001, 1, 1, 0, 2'd0, 8'hA0);
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0001, 1, 1, 0, 2'd0, 8'hA0);
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0001, 1, 1, 0, 2'd0, 8'hA0);
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0000, 0, 0, 1, 2'd0, 8'h00);
    addVec(1, 1, 4'b0011, 4'b0010, 0, 4'b0010, 1, 1, 0, 2'd1, 8'hA1);
    addVec(1, 1, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd1, 8'h00);
    addVec(1, 1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0, 2'd0, 8'hA0);
    runTable("trunc");

    // MAXBURST=4: last arriving on beat 4 is a normal end, no trunc.
    applyReset();
    addVec(1, 1, 4'b1000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0, 8'h00);
    addVec(1, 1, 4'b1000, 4'b0000, 0, 4'b1000, 1, 1, 0, 2'd3, 8'hA3);
    addVec(1, 1, 4'b1000, 4'b0000, 0, 4'b1000, 1, 1, 0, 2'd3, 8'hA3);
    addVec(1, 1, 4'b1000, 4'b0000, 0, 4'b1000, 1, 1, 0, 2'd3, 8'hA3);
    addVec(1, 1, 4'b1000, 4'b1000, 0, 4'b1000, 1, 1, 0, 2'd3, 8'hA3);
    addVec(1, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd3, 8'h00);
    runTable("last_at_max");

    // All four requesters with single-beat packets: 0,1,2,3,0,1,2,3.
    applyReset();
    for (int r = 0; r < 4; r++) begin
      loadBeat(r, 0, 1'b1);
      loadBeat(r, 1, 1'b1);
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++) expectBeat(r, k);
    runUntilEmpty("rotation_done", 40);

    // Requester 2 five-beat packet, FIFO full for 3 cycles after beat 1;
    // requester 3 must wait for the whole packet.
    applyReset();
    loadPacket(2, 0, 5);
    loadBeat(3, 0, 1'b1);
    for (int k = 0; k < 5; k++) expectBeat(2, k);
    expectBeat(3, 0);
    stall_after = 1;
    stall_left  = 3;
    stall_gnt   = 2'd2;
    runUntilEmpty("stall_done", 40);

    // arb_en dropped once the burst owns the FIFO: burst completes, no new grant.
    applyReset();
    loadPacket(1, 0, 3);
    for (int k = 0; k < 3; k++) expectBeat(1, k);
    applyStimulus();
    arb_en = 1'b0;
    loadBeat(0, 0, 1'b1);
    runUntilEmpty("arb_off_burst", 10);
    for (int n = 0; n < 4; n++) begin
      applyStimulus();
      checkOutput("arb_off_idle", {busy, winc}, 0);
    end
    arb_en = 1'b1;
    expectBeat(0, 0);
    runUntilEmpty("arb_on_grant", 10);

    // Reset during beat 3 of a burst from requester 2.
    applyReset();
    loadPacket(2, 0, 5);
    expectBeat(2, 0);
    expectBeat(2, 1);
    applyStimulus();
    loadBeat(0, 0, 1'b1);
    runUntilEmpty("pre_reset_beats", 10);
    driveSources();
    #1;
    checkOutput("beat3_inflight", {winc, gnt_id}, {1'b1, 2'd2});
    wrst_n = 1'b0;
    #1;
    checkOutput("reset_mid_burst", {req_ready, winc, busy, gnt_id}, 0);
    for (int n = 0; n < 2; n++) begin
      @(negedge wclk);
      checkOutput("reset_hold_winc", winc, 0);
    end
    wrst_n = 1'b1;
    expectBeat(0, 0);
    for (int k = 2; k < 5; k++) expectBeat(2, k);
    runUntilEmpty("post_reset_order", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
